// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, round constants and key-schedule word helpers
package aes_pkg;
  localparam int AES_NR = 10;
  localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  typedef logic [31:0] word_t;
  typedef logic [127:0] key_t;
  typedef enum logic [1:0] {IDLE, EMIT, SUB} state_t;
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic key_t next_key(input key_t k, input word_t sub, input logic [7:0] rc);
    word_t t, w0, w1, w2, w3;
    t = sub ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/sbox.sv
// sbox: combinational forward AES S-box
module sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  localparam logic [7:0] TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign s = TBL[a];
endmodule

// File: rtl/aes_key_sched.sv
// aes_key_sched: AES-128 round key stream over valid/ready; SBOX_SHARED_EN time-multiplexes one S-box
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         key_valid_o,
  input  logic         key_ready_i,
  output logic [127:0] key_o,
  output logic [3:0]   round_o,
  output logic         done_o
);
  if (NR != AES_NR) begin : g_bad_nr
    $error("aes_key_sched supports only NR=10");
  end
  state_t state;
  word_t rot;
  logic [7:0] rc;
  logic acc, last;
  assign rot = rot_word(key_o[31:0]);
  assign rc = RCON[round_o < 4'(NR) ? round_o : 4'd0];
  assign acc = key_valid_o & key_ready_i;
  assign last = round_o == 4'(NR);
`ifdef SBOX_SHARED_EN
  logic [1:0] cnt;
  word_t tmp;
  logic [7:0] sb_y;
  sbox u_sbox (.a(rot[{cnt, 3'b000} +: 8]), .s(sb_y));
`else
  word_t sub;
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
  end
`endif
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
      busy_o <= 1'b0;
      key_valid_o <= 1'b0;
      done_o <= 1'b0;
      key_o <= '0;
      round_o <= '0;
`ifdef SBOX_SHARED_EN
      cnt <= '0;
      tmp <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      if (state == IDLE) begin
        if (start_i) begin
          key_o <= key_i;
          round_o <= '0;
          key_valid_o <= 1'b1;
          busy_o <= 1'b1;
          state <= EMIT;
        end
      end else if (state == EMIT) begin
        if (acc && last) begin
          key_valid_o <= 1'b0;
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state <= IDLE;
        end else if (acc) begin
`ifdef SBOX_SHARED_EN
          key_valid_o <= 1'b0;
          cnt <= '0;
          state <= SUB;
`else
          key_o <= next_key(key_o, sub, rc);
          round_o <= round_o + 4'd1;
`endif
        end
      end
`ifdef SBOX_SHARED_EN
      else begin
        // byte 3 lands on the last SUB cycle, so it is taken straight from the S-box
        tmp[{cnt, 3'b000} +: 8] <= sb_y;
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          key_o <= next_key(key_o, {sb_y, tmp[23:0]}, rc);
          round_o <= round_o + 4'd1;
          key_valid_o <= 1'b1;
          state <= EMIT;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: randomized scoreboard bench against a FIPS-197 KeyExpansion model
module tb_aes_key_sched;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic busy_o, key_valid_o, done_o;
  logic key_ready_i = 1'b0;
  logic [127:0] key_o;
  logic [3:0] round_o;

  aes_key_sched dut (
    .clk(clk), .nreset(nreset), .start_i(start_i), .key_i(key_i), .busy_o(busy_o),
    .key_valid_o(key_valid_o), .key_ready_i(key_ready_i), .key_o(key_o),
    .round_o(round_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {logic [3:0] r; logic [127:0] k;} exp_t;
  exp_t exp_q[$];
  logic [127:0] got [16];
  logic [7:0] sb [256];
  int vectors = 0, miscompares = 0, cyc = 0;
  bit bp = 1'b0;
`ifdef SBOX_SHARED_EN
  localparam int LAT10 = 50;
`else
  localparam int LAT10 = 10;
`endif

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_expected(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_q.push_back('{4'(r), {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    key_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  initial begin : monitor
    bit prev_stall = 1'b0;
    logic [127:0] prev_key;
    logic [3:0] prev_round;
    exp_t e;
    forever begin
      @(negedge clk);
      if (nreset && prev_stall) begin
        chk("stall_valid", key_valid_o, 1);
        chk("stall_key", key_o, prev_key);
        chk("stall_round", round_o, prev_round);
      end
      if (nreset && key_valid_o && key_ready_i) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_key: got round %0d key %h, expected none", round_o, key_o);
        end else begin
          e = exp_q.pop_front();
          chk("round", round_o, e.r);
          chk("key", key_o, e.k);
          got[round_o] = key_o;
        end
      end
      prev_stall = nreset && key_valid_o && !key_ready_i;
      prev_key = key_o;
      prev_round = round_o;
    end
  end

  task automatic run(input logic [127:0] key, input bit rbp, input bit inj, input bit fin, input bit rst);
    int t0, t10 = -1, dn = 0;
    bit fired = 1'b0, fin_hit = 1'b0;
    bp = rbp;
    push_expected(key);
    key_i = key;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    t0 = cyc;
    chk("r0_latency", {key_valid_o, busy_o, round_o}, {1'b1, 1'b1, 4'd0});
    for (int g = 0; g < 600 && busy_o; g++) begin
      if (key_valid_o && round_o == 4'd10 && t10 < 0) t10 = cyc;
      if (rst && key_valid_o && round_o == 4'd6) begin
        nreset = 1'b0;
        tick();
        chk("rst_valid", key_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_key", key_o, 0);
        chk("rst_round", round_o, 0);
        nreset = 1'b1;
        exp_q.delete();
        return;
      end
      if (inj && !fired && key_valid_o && round_o == 4'd4) begin
        key_i = ~key;
        start_i = 1'b1;
        fired = 1'b1;
      end
      if (fin && key_valid_o && round_o == 4'd10 && key_ready_i) begin
        start_i = 1'b1;
        fin_hit = 1'b1;
      end
      tick();
      start_i = 1'b0;
      if (done_o) dn++;
      if (fin_hit) begin
        chk("fin_busy", busy_o, 0);
        chk("fin_done", done_o, 1);
      end
    end
    if (busy_o) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: busy_o still %0b after cycle budget, expected 0", busy_o);
    end
    if (fin) chk("fin_seen", fin_hit, 1);
    if (inj) chk("inj_seen", fired, 1);
    if (!rbp) chk("round10_latency", 128'(t10 - t0), 128'(LAT10));
    tick();
    if (done_o) dn++;
    chk("done_pulses", dn, 1);
    chk("post_valid", {key_valid_o, busy_o}, 2'b00);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    build_sbox();
    repeat (3) tick();
    key_ready_i = 1'b0;
    chk("reset_valid", key_valid_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_key", key_o, 0);
    chk("reset_round", round_o, 0);
    nreset = 1'b1;
    tick();
    run(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, 0, 0);
    chk("fips_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run(128'h0, 0, 0, 0, 0);
    chk("zero_r1", got[1], 128'h62636363626363636263636362636363);
    chk("zero_r10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    run(128'h2b7e151628aed2a6abf7158809cf4f3c, 1, 0, 0, 0);
    chk("bp_fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    repeat (4) run({$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, 0);
    run({$urandom, $urandom, $urandom, $urandom}, 1, 1, 0, 0);
    run({$urandom, $urandom, $urandom, $urandom}, 0, 0, 1, 0);
    run({$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, 1);
    tick();
    run(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 0, 0, 0);
    chk("after_rst_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aes_key_sched.md
Name: aes_key_sched

Overview:
- AES-128 encryption-side key schedule (FIPS-197 KeyExpansion). Loads a 128-bit cipher key and emits round keys 0..10 in order over a valid/ready handshake.
- Serves the encryption datapath and is the forward-direction counterpart of the inverse byte substitution used in decryption.
- SubWord uses the forward S-box, instantiated as sub-module `sbox`.
- One round key is produced per accepted handshake.

Parameters:
- NR, 10, number of rounds; fixed for AES-128. Other values are unsupported, and elaboration must fail on any other value.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- nreset  in  1  synchronous, active-low reset.
- start_i  in  1  load key_i and begin a schedule; sampled only in IDLE.
- key_i  in  128  cipher key; key_i[127:120] is byte 0, key_i[127:96] is w0.
- busy_o  out  1  high from start acceptance until round NR is accepted.
- key_valid_o  out  1  key_o and round_o are valid.
- key_ready_i  in  1  consumer accepts the current round key.
- key_o  out  128  current round key, same byte order as key_i.
- round_o  out  4  index of key_o, 0..NR.
- done_o  out  1  one-cycle pulse after round NR is accepted.

Behaviour:
- Reset (nreset=0 at a clk edge):
  - state=IDLE.
  - busy_o=0, key_valid_o=0, done_o=0, key_o=0, round_o=0.
  - Reset mid-schedule aborts it immediately; nothing resumes.
- States: IDLE, EMIT, plus SUB when SBOX_SHARED_EN is defined.
- IDLE:
  - start_i=1 → key_o<=key_i, round_o<=0, key_valid_o<=1, busy_o<=1, go to EMIT.
  - Round 0 key is therefore valid one cycle after start.
- EMIT:
  - Outputs hold stable while key_valid_o=1 and key_ready_i=0.
  - Accept condition: key_valid_o & key_ready_i.
  - Accept with round_o<NR: key_o <= next(key_o, RCON[round_o]), round_o <= round_o+1.
    - key_valid_o stays 1, so there are zero bubbles.
    - Round keys stream one per cycle while key_ready_i is held high.
  - Accept with round_o==NR: key_valid_o<=0, busy_o<=0, done_o<=1 for one cycle, go to IDLE.
- next(w0..w3, rc):
  - t = SubWord(RotWord(w3)) ^ {rc,24'h0}, where RotWord(w) = {w[23:0], w[31:24]}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- RCON, indexed by round_o 0..9: 01,02,04,08,10,20,40,80,1B,36.
- start_i while busy_o=1 is ignored; key_i is not sampled.
- key_ready_i while key_valid_o=0 has no effect.
- Simultaneous start_i with the final accept: the final accept wins and start_i is ignored. start_i is honoured only from the following IDLE cycle.
- round_o never exceeds NR and never wraps.

Optional Feature:
- Macro: SBOX_SHARED_EN.
- Defined:
  - A single `sbox` instance is time-multiplexed over the 4 bytes of RotWord(w3).
  - On each accept with round_o<NR, the block goes to SUB with key_valid_o=0.
  - A 2-bit byte counter substitutes one byte per cycle into a 32-bit temp register.
  - After 4 cycles the new key is registered, key_valid_o=1, and the block returns to EMIT.
  - Round k+1 appears exactly 5 cycles after the accept of round k.
  - key_ready_i is ignored in SUB.
- Undefined: four parallel `sbox` instances and no SUB state, giving the zero-bubble behaviour above.
- Key values are identical in both builds.

Decomposition:
- Package `aes_pkg`:
  - AES_NR=10.
  - RCON constant array [0:9] of 8-bit.
  - 32-bit word typedef and 128-bit key typedef.
  - State enum {IDLE, EMIT, SUB}.
  - Function rot_word.
- Sub-module `sbox`: combinational 8-bit forward AES S-box, 8-bit in / 8-bit out.
  - Instantiated 4× by default, 1× under SBOX_SHARED_EN.
  - Reusable by the encryption round datapath.

Test Plan:
- FIPS-197 key:
  - Stimulus: key_i=2b7e151628aed2a6abf7158809cf4f3c, key_ready_i=1, pulse start_i.
  - Response: round 0 = key_i; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 on consecutive cycles (default build); done_o pulses once.
- All-zero key:
  - Response: round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure:
  - Stimulus: toggle key_ready_i randomly.
  - Response: key_o and round_o remain stable while valid and not ready; round sequence 0..10 has no skips or duplicates; the same 11 values as the unstalled run.
- start_i during busy:
  - Stimulus: assert start_i with a different key at round 4.
  - Response: ignored; the schedule completes with the original key.
  - Also assert start_i in the same cycle as the final accept: ignored, busy_o=0 next cycle.
- Reset mid-run:
  - Stimulus: nreset=0 at round 6.
  - Response: next cycle all outputs are 0 and state is IDLE; a new start then yields a correct round 0.
- SBOX_SHARED_EN build:
  - Response: same FIPS vectors as the default build; key_valid_o is low for exactly 4 cycles between accepts; round 10 is valid 50 cycles after round 0.
